// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage load/store engine.
// Takes one live load or store from the EX/MEM register and issues it as a
// single valid/ready bus request. It then waits for the response and
// returns the aligned, extended load data to write-back. While the access is
// outstanding, hold_req freezes EX/MEM and the stages upstream of it.
//
// Ports
//   clk, rstn                    clock, synchronous active-low reset
//   mem_valid/is_load/is_store   live instruction in MEM and its kind
//   funct3, addr, wdata          RISC-V width/sign code, effective address, store data
//   hold_req                     stall request (comb)
//   req_*                        bus request channel (valid/ready), registered
//   rsp_valid/rsp_err/rsp_rdata  bus response (1-cycle pulse)
//   load_done, load_data         load result pulse and data
//   misalign                     misaligned access pulse (comb, no bus traffic)
//   access_fault                 bus error pulse
module mem_access_unit #(
  parameter int XLEN = 64
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              mem_valid,
  input  logic              is_load,
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [XLEN-1:0]   addr,
  input  logic [XLEN-1:0]   wdata,
  output logic              hold_req,
  output logic              req_valid,
  input  logic              req_ready,
  output logic              req_we,
  output logic [XLEN-1:0]   req_addr,
  output logic [XLEN-1:0]   req_wdata,
  output logic [XLEN/8-1:0] req_wstrb,
  input  logic              rsp_valid,
  input  logic              rsp_err,
  input  logic [XLEN-1:0]   rsp_rdata,
  output logic              load_done,
  output logic [XLEN-1:0]   load_data,
  output logic              misalign,
  output logic              access_fault
);
  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;
  state_t state;

  logic [OW-1:0]   off, off_q;
  logic [1:0]      size_q;
  logic            uns_q, ld_q;
  logic            access, mis, start;
  logic [NB-1:0]   strb;
  logic [XLEN-1:0] rsh, ext;

  assign off    = addr[OW-1:0];
  assign access = mem_valid & (is_load | is_store);

  // Natural alignment: the offset must be a multiple of the access size.
  always_comb begin
    mis = 1'b0;
    case (funct3[1:0])
      2'b00:   mis = 1'b0;
      2'b01:   mis = off[0];
      2'b10:   mis = |off[1:0];
      default: mis = |off;
    endcase
  end

  assign start    = (state == S_IDLE) & access & ~mis;
  assign misalign = (state == S_IDLE) & access & mis;
  assign hold_req = start | (state == S_REQ) | (state == S_WAIT);

  always_comb begin
    strb = '1;
    case (funct3[1:0])
      2'b00:   strb = NB'(1)    << off;
      2'b01:   strb = NB'(3)    << off;
      2'b10:   strb = NB'(4'hF) << off;
      default: strb = '1;
    endcase
  end

  // Bring the addressed bytes down to bit 0, then extend them according to
  // the width and signedness latched when the request was issued.
  assign rsh = rsp_rdata >> {off_q, 3'b000};

  always_comb begin
    ext = rsh;
    case ({uns_q, size_q})
      3'b000:  ext = {{(XLEN-8){rsh[7]}},   rsh[7:0]};
      3'b001:  ext = {{(XLEN-16){rsh[15]}}, rsh[15:0]};
      3'b010:  ext = {{(XLEN-32){rsh[31]}}, rsh[31:0]};
      3'b100:  ext = {{(XLEN-8){1'b0}},     rsh[7:0]};
      3'b101:  ext = {{(XLEN-16){1'b0}},    rsh[15:0]};
      3'b110:  ext = {{(XLEN-32){1'b0}},    rsh[31:0]};
      default: ext = rsh;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state        <= S_IDLE;
      req_valid    <= 1'b0;
      req_we       <= 1'b0;
      req_addr     <= '0;
      req_wdata    <= '0;
      req_wstrb    <= '0;
      load_done    <= 1'b0;
      load_data    <= '0;
      access_fault <= 1'b0;
      off_q        <= '0;
      size_q       <= '0;
      uns_q        <= 1'b0;
      ld_q         <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          req_valid <= 1'b1;
          req_we    <= is_store;
          req_addr  <= addr;
          req_wdata <= wdata << {off, 3'b000};
          req_wstrb <= is_store ? strb : '0;
          off_q     <= off;
          size_q    <= funct3[1:0];
          uns_q     <= funct3[2];
          ld_q      <= is_load;
          state     <= S_REQ;
        end
        // req_* fields are only written in IDLE, so they stay stable here.
        S_REQ: if (req_ready) begin
          req_valid <= 1'b0;
          state     <= S_WAIT;
        end
        S_WAIT: if (rsp_valid) begin
          if (ld_q) begin
            load_done <= 1'b1;
            load_data <= rsp_err ? '0 : ext;
          end
          access_fault <= rsp_err;
          state        <= S_DONE;
        end
        default: begin
          load_done    <= 1'b0;
          access_fault <= 1'b0;
          state        <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases followed by
// randomized accesses, each compared against an arithmetic reference model.
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        rstn;
  logic        mem_valid, is_load, is_store;
  logic [2:0]  funct3;
  logic [63:0] addr, wdata;
  logic        hold_req, req_valid, req_ready, req_we;
  logic [63:0] req_addr, req_wdata;
  logic [7:0]  req_wstrb;
  logic        rsp_valid, rsp_err;
  logic [63:0] rsp_rdata;
  logic        load_done, misalign, access_fault;
  logic [63:0] load_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.XLEN(64)) dut (
    .clk(clk), .rstn(rstn),
    .mem_valid(mem_valid), .is_load(is_load), .is_store(is_store),
    .funct3(funct3), .addr(addr), .wdata(wdata),
    .hold_req(hold_req),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .load_done(load_done), .load_data(load_data),
    .misalign(misalign), .access_fault(access_fault)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference model: plain arithmetic on access size and byte offset.
  function automatic int nbytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit ref_mis(input logic [2:0] f3, input int off);
    return (off % nbytes(f3)) != 0;
  endfunction

  function automatic logic [7:0] ref_strb(input logic [2:0] f3, input int off);
    int m;
    m = ((1 << nbytes(f3)) - 1) << off;
    return m[7:0];
  endfunction

  function automatic logic [63:0] ref_load(input logic [2:0] f3, input int off,
                                           input logic [63:0] rd);
    logic [63:0] r, mask, v;
    int bits;
    r = rd >> (8 * off);
    bits = 8 * nbytes(f3);
    if (bits == 64) return r;
    mask = (64'd1 << bits) - 64'd1;
    v = r & mask;
    if (!f3[2] && r[bits-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_req_valid"}, 64'(req_valid), 64'd0);
    chk({tag, "_req_we"}, 64'(req_we), 64'd0);
    chk({tag, "_req_addr"}, req_addr, 64'd0);
    chk({tag, "_req_wdata"}, req_wdata, 64'd0);
    chk({tag, "_req_wstrb"}, 64'(req_wstrb), 64'd0);
    chk({tag, "_load_done"}, 64'(load_done), 64'd0);
    chk({tag, "_load_data"}, load_data, 64'd0);
    chk({tag, "_access_fault"}, 64'(access_fault), 64'd0);
    chk({tag, "_hold_req"}, 64'(hold_req), 64'd0);
    chk({tag, "_misalign"}, 64'(misalign), 64'd0);
  endtask

  // One complete access. Entered and left at posedge+1.
  task automatic access(input string tag, input bit ld, input logic [2:0] f3,
                        input logic [63:0] a, input logic [63:0] wd,
                        input int rdly, input int wdly,
                        input logic [63:0] rd, input bit err);
    int off;
    bit m;
    logic [63:0] ewd;
    logic [7:0] estrb;
    off   = int'(a[2:0]);
    m     = ref_mis(f3, off);
    ewd   = wd << (8 * off);
    estrb = ld ? 8'h00 : ref_strb(f3, off);

    mem_valid = 1'b1; is_load = ld; is_store = ~ld;
    funct3 = f3; addr = a; wdata = wd;
    #1;
    chk({tag, "_misalign"}, 64'(misalign), 64'(m));
    chk({tag, "_hold_idle"}, 64'(hold_req), 64'(!m));
    if (m) begin
      step();
      mem_valid = 1'b0;
      #1;
      chk({tag, "_mis_no_req"}, 64'(req_valid), 64'd0);
      chk({tag, "_mis_no_hold"}, 64'(hold_req), 64'd0);
      return;
    end
    step();
    // Inputs change after issue; the in-flight access must not notice.
    mem_valid = 1'($urandom_range(0, 1));
    addr = {$urandom, $urandom}; wdata = {$urandom, $urandom};
    funct3 = 3'($urandom_range(0, 7));
    for (int i = 0; i <= rdly; i++) begin
      chk({tag, "_req_valid"}, 64'(req_valid), 64'd1);
      chk({tag, "_req_we"}, 64'(req_we), 64'(!ld));
      chk({tag, "_req_addr"}, req_addr, a);
      chk({tag, "_req_wdata"}, req_wdata, ewd);
      chk({tag, "_req_wstrb"}, 64'(req_wstrb), 64'(estrb));
      chk({tag, "_hold_req"}, 64'(hold_req), 64'd1);
      req_ready = (i == rdly);
      step();
    end
    req_ready = 1'b0;
    for (int i = 0; i <= wdly; i++) begin
      chk({tag, "_wait_valid"}, 64'(req_valid), 64'd0);
      chk({tag, "_wait_hold"}, 64'(hold_req), 64'd1);
      chk({tag, "_wait_done"}, 64'(load_done), 64'd0);
      if (i == wdly) begin
        rsp_valid = 1'b1; rsp_err = err; rsp_rdata = rd;
      end
      step();
    end
    rsp_valid = 1'b0; rsp_err = 1'b0; rsp_rdata = {$urandom, $urandom};
    chk({tag, "_load_done"}, 64'(load_done), 64'(ld));
    chk({tag, "_fault"}, 64'(access_fault), 64'(err));
    chk({tag, "_done_hold"}, 64'(hold_req), 64'd0);
    if (ld) chk({tag, "_load_data"}, load_data, err ? 64'd0 : ref_load(f3, off, rd));
    mem_valid = 1'b0;
    step();
    chk({tag, "_pulse_end"}, 64'(load_done), 64'd0);
    chk({tag, "_fault_end"}, 64'(access_fault), 64'd0);
    chk({tag, "_idle_hold"}, 64'(hold_req), 64'd0);
  endtask

  initial begin
    bit ld;
    logic [2:0] f3;
    logic [63:0] a;

    rstn = 1'b0; mem_valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
    funct3 = 3'd0; addr = '0; wdata = '0; req_ready = 1'b0;
    rsp_valid = 1'b0; rsp_err = 1'b0; rsp_rdata = '0;
    step(); step();
    chk_idle_outputs("reset");
    rstn = 1'b1;
    step();

    // SW, ready on first REQ cycle
    access("sw", 1'b0, 3'b010, 64'h1004, 64'h11223344, 0, 1, 64'd0, 1'b0);
    chk("sw_wdata_abs", req_wdata, 64'h11223344_00000000);
    chk("sw_strb_abs", 64'(req_wstrb), 64'hF0);
    // LB sign extension
    access("lb", 1'b1, 3'b000, 64'h2003, 64'd0, 0, 0, 64'h00000000_80000000, 1'b0);
    chk("lb_abs", load_data, 64'hFFFF_FFFF_FFFF_FF80);
    // LHU zero extension from the top half-word
    access("lhu", 1'b1, 3'b101, 64'h2006, 64'd0, 1, 2, 64'hBEEF_0000_0000_0000, 1'b0);
    chk("lhu_abs", load_data, 64'h0000_0000_0000_BEEF);
    // Misaligned LW
    access("lw_mis", 1'b1, 3'b010, 64'h3002, 64'd0, 0, 0, 64'd0, 1'b0);
    // Ready delayed five cycles, bus error
    access("ld_err", 1'b1, 3'b011, 64'h4000, 64'd0, 5, 1, 64'h1234_5678_9ABC_DEF0, 1'b1);

    // Reset while waiting for the response; later response is ignored.
    mem_valid = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'b011; addr = 64'h5000;
    step();
    mem_valid = 1'b0; req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    chk("rst_wait_hold", 64'(hold_req), 64'd1);
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    rsp_valid = 1'b1; rsp_rdata = 64'hDEAD_BEEF_CAFE_F00D;
    step();
    rsp_valid = 1'b0;
    chk_idle_outputs("rst_mid");
    step();
    chk("rst_mid_done2", 64'(load_done), 64'd0);

    // Randomized accesses
    for (int n = 0; n < 60; n++) begin
      ld = 1'($urandom_range(0, 1));
      f3 = ld ? 3'($urandom_range(0, 6)) : 3'($urandom_range(0, 3));
      a  = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) a[2:0] = a[2:0] & ~3'(nbytes(f3) - 1);
      access($sformatf("rnd%0d", n), ld, f3, a, {$urandom, $urandom},
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             {$urandom, $urandom}, ($urandom_range(0, 7) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
